mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter and sequencer for the 4-to-1, 8-bit mux tree. It shares the tree between four requesters. Each cycle it picks at most one pending requester and drives the tree's three select lines to route that requester's byte. It captures the tree output into a registered valid/ready output stage and returns a one-cycle grant pulse to the winner. The block sits between the four byte sources and a single downstream consumer; the mux tree itself stays external.

## Interface
Parameters: none (widths fixed: 8-bit data, 4 requesters).

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req  in  4  request per requester; bit i = requester i (0→a, 1→b, 2→c, 3→d)
- lock  in  4  burst-lock request per requester; used only when the configuration macro is defined, ignored otherwise
- mux_f  in  8  output of the external mux tree
- sel1  out  1  tree select, pair a/b: 1 = a, 0 = b
- sel2  out  1  tree select, pair c/d: 1 = c, 0 = d
- sel3  out  1  tree select, final stage: 1 = a/b pair, 0 = c/d pair
- gnt  out  4  one-hot pulse, one cycle, marks the requester whose byte was captured this edge
- out_data  out  8  registered byte to consumer
- out_valid  out  1  out_data holds an unconsumed byte
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready

## Operation
- FSM states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Slot free: free = (state==EMPTY) || out_ready.
- Take: take = free && |req.
- Winner selection is combinational.
  - Round-robin pointer `last` (2 bits) holds the most recent winner.
  - Priority order is last+1, last+2, last+3, last, all mod 4.
  - The first set req bit in that order wins.
- sel encoding from the winner:
  - 0: sel1=1, sel2=1, sel3=1
  - 1: sel1=0, sel2=1, sel3=1
  - 2: sel1=1, sel2=1, sel3=0
  - 3: sel1=1, sel2=0, sel3=0
  - No take: all sels = 1.
- On an edge with take:
  - out_data ← mux_f; state → FULL.
  - gnt ← onehot(winner), else gnt ← 0.
  - last ← winner.
- On an edge with out_valid && out_ready && !take: state → EMPTY; out_data holds its last value.
- Simultaneous consume and take: back-to-back transfer, state stays FULL, throughput 1 byte per cycle.
- FULL && !out_ready: no take, sels = 1, gnt = 0. out_data and out_valid are stable until accepted.
- Requesters keep req asserted until they see their gnt pulse. A req deasserted before its grant is simply not served (no memory of it).

## Timing
- Reset values:
  - out_valid=0, out_data=8'h00, gnt=4'b0000, state=EMPTY.
  - last=3, so requester 0 has top priority first.
  - Lock owner cleared.
- sel1/sel2/sel3 are combinational from req, state, out_ready and `last`. mux_f must settle within the same cycle.
- Latency: req sampled at edge N → out_valid and gnt at edge N (visible after edge N). One cycle from req assertion to data presentation.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronous); the pending byte is dropped.
- Reset deassertion is synchronized externally; no requirement is placed on the block for it.
- gnt is never asserted with out_valid falling on the same edge.

## Configuration
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - If the winner has lock[winner]=1 at its take edge, it becomes lock owner.
  - While the owner keeps req[owner]=1 and lock[owner]=1, it wins every take regardless of round-robin order; `last` still updates.
  - Ownership is released on the first cycle either bit is 0. Normal round-robin then resumes from last=owner.
  - Reset clears ownership.
- Not defined: lock input is ignored, no owner register is built, pure round-robin.

## Test plan
- Reset then req=4'b1111, out_ready=1, a..d=8'h11/22/33/44 → gnt sequence 0001,0010,0100,1000,0001; out_data 11,22,33,44,11 on consecutive cycles.
- req=4'b0100 only, out_ready=0 → one capture of 8'h33, gnt=0100 for one cycle; out_valid stays 1, sels all 1, gnt 0 until out_ready=1.
- FULL with out_ready=1 and req=0 → out_valid drops next edge, out_data unchanged.
- Assert rst mid-stream with out_valid=1 → out_valid=0, out_data=00, gnt=0 immediately. First grant after release goes to requester 0 when req=4'b1111.
- req=4'b1010 after last=1 → requester 3 wins (sel2=0, sel3=0), then requester 1.
- MUX_ARB_LOCK_EN: req=1111, lock=0010 → requester 1 wins 3 consecutive takes. lock[1]=0 → next winner is requester 2.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter and sequencer for a 4-to-1 8-bit mux tree (optional burst lock: MUX_ARB_LOCK_EN)
module mux_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] lock,
    input  logic [7:0] mux_f,
    output logic       sel1,
    output logic       sel2,
    output logic       sel3,
    output logic [3:0] gnt,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] last;
    logic [1:0] rr_winner;
    logic [1:0] rr_idx;
    logic       rr_found;
    logic [1:0] winner;
    logic       free;
    logic       take;

    // The output slot can accept a new byte when empty or when the current one leaves this edge.
    assign free      = (state == EMPTY) || out_ready;
    assign take      = free && (|req);
    assign out_valid = (state == FULL);

    // Round-robin search starting just after the most recent winner, wrapping back to it last.
    always_comb begin
        rr_winner = last;
        rr_idx    = last;
        rr_found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            rr_idx = last + 2'(k);
            if (!rr_found && req[rr_idx]) begin
                rr_winner = rr_idx;
                rr_found  = 1'b1;
            end
        end
    end

`ifdef MUX_ARB_LOCK_EN
    logic [1:0] owner;
    logic       owner_valid;
    logic       owner_hold;

    // The owner keeps the tree only while it holds both its request and its lock.
    assign owner_hold = owner_valid && req[owner] && lock[owner];
    assign winner     = owner_hold ? owner : rr_winner;

    // Track the burst-lock owner: claimed on a locked take, dropped as soon as req or lock falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= 2'd0;
            owner_valid <= 1'b0;
        end else if (take && lock[winner]) begin
            owner       <= winner;
            owner_valid <= 1'b1;
        end else if (!owner_hold) begin
            owner_valid <= 1'b0;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^lock;
    assign winner      = rr_winner;
`endif

    // Output-stage occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next occupancy and tree selects; selects idle high when nothing is being captured.
    always_comb begin
        state_next = state;
        sel1       = 1'b1;
        sel2       = 1'b1;
        sel3       = 1'b1;
        if (take) begin
            state_next = FULL;
            case (winner)
                2'd0: begin
                    sel1 = 1'b1;
                    sel2 = 1'b1;
                    sel3 = 1'b1;
                end
                2'd1: begin
                    sel1 = 1'b0;
                    sel2 = 1'b1;
                    sel3 = 1'b1;
                end
                2'd2: begin
                    sel1 = 1'b1;
                    sel2 = 1'b1;
                    sel3 = 1'b0;
                end
                default: begin
                    sel1 = 1'b1;
                    sel2 = 1'b0;
                    sel3 = 1'b0;
                end
            endcase
        end else if ((state == FULL) && out_ready) begin
            state_next = EMPTY;
        end
    end

    // Capture the routed byte, pulse the winner's grant and advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= 8'h00;
            gnt      <= 4'b0000;
            last     <= 2'd3;
        end else begin
            if (take) begin
                out_data <= mux_f;
                gnt      <= 4'b0001 << winner;
                last     <= winner;
            end else begin
                gnt      <= 4'b0000;
            end
        end
    end

endmodule
